// File: rtl/sme_param_if.sv
// Byte-bus load channel and result channel of the sme_param string-matching engine.
interface sme_param_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
);
  logic [DATA_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              busy;
  logic              valid;
  logic              match;
  logic [IDX_W-1:0]  match_index;
  logic              ovf;

  modport master (output chardata, isstring, ispattern,
                  input  busy, valid, match, match_index, ovf);
  modport slave  (input  chardata, isstring, ispattern,
                  output busy, valid, match, match_index, ovf);
endinterface

// File: rtl/sme_param.sv
// Parametrised string-matching engine: leftmost match with '.', '^', '$' and one '*'.
// Optional feature macro: SME_NOCASE_EN (case-insensitive letter compare).
module sme_param #(
  parameter int DATA_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  sme_param_if.slave bus
);
  localparam int IDX_W = $clog2(STR_MAX);
  localparam int LEN_W = $clog2(STR_MAX + 1);
  localparam int PI_W  = $clog2(PAT_MAX + 1);
  localparam int PA_W  = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam logic [LEN_W-1:0]  STR_CAP  = LEN_W'(STR_MAX);
  localparam logic [PI_W-1:0]   PAT_CAP  = PI_W'(PAT_MAX);
  localparam logic [DATA_W-1:0] CH_DOT   = DATA_W'(8'h2E);
  localparam logic [DATA_W-1:0] CH_CARET = DATA_W'(8'h5E);
  localparam logic [DATA_W-1:0] CH_DOLL  = DATA_W'(8'h24);
  localparam logic [DATA_W-1:0] CH_STAR  = DATA_W'(8'h2A);
  localparam logic [DATA_W-1:0] CH_SP    = DATA_W'(8'h20);

  typedef enum logic [2:0] {IDLE, RECV_S, RECV_P, SEARCH, DONE} state_t;
  state_t state_reg;

  logic [DATA_W-1:0] str_mem [STR_MAX];
  logic [DATA_W-1:0] pat_mem [PAT_MAX];

  logic [LEN_W-1:0] str_len_reg, start_reg, si_reg, bt_reg;
  logic [PI_W-1:0]  pat_len_reg, pi_reg, star_pos_reg;
  logic             s_ovf_reg, p_ovf_reg, anc_s_reg, anc_e_reg, star_ok_reg, star_act_reg;
  logic             busy_reg, valid_reg, match_reg, ovf_reg;
  logic [IDX_W-1:0] idx_reg;

  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] c);
`ifdef SME_NOCASE_EN
    if (c >= DATA_W'(8'h41) && c <= DATA_W'(8'h5A)) return c | CH_SP;
`endif
    return c;
  endfunction

  // Write strobes: a load burst starting from IDLE/DONE restarts at index 0.
  logic str_first, str_wr, pat_first, pat_app, pat_wr;
  logic [IDX_W-1:0] str_wa;
  logic [PA_W-1:0]  pat_wa;
  assign str_first = (state_reg == IDLE || state_reg == DONE) && bus.isstring;
  assign str_wr    = str_first ||
                     (state_reg == RECV_S && bus.isstring && str_len_reg < STR_CAP);
  assign str_wa    = str_first ? '0 : IDX_W'(str_len_reg);
  assign pat_first = (state_reg == IDLE || state_reg == DONE || state_reg == RECV_S) &&
                     bus.ispattern && !bus.isstring;
  assign pat_app   = state_reg == RECV_P && bus.ispattern && !bus.isstring;
  assign pat_wr    = pat_first || (pat_app && pat_len_reg < PAT_CAP);
  assign pat_wa    = pat_first ? '0 : PA_W'(pat_len_reg);

  always_ff @(posedge clk) begin
    if (str_wr) str_mem[str_wa] <= bus.chardata;
    if (pat_wr) pat_mem[pat_wa] <= bus.chardata;
  end

  // Pattern body excludes honoured anchors: [p0, pe).
  logic [PI_W-1:0]   p0, pe;
  logic [DATA_W-1:0] str_c, prev_c, pat_c;
  logic              chars_eq, at_first;
  assign p0       = PI_W'(anc_s_reg);
  assign pe       = anc_e_reg ? pat_len_reg - PI_W'(1) : pat_len_reg;
  assign str_c    = (si_reg < str_len_reg) ? str_mem[IDX_W'(si_reg)] : '0;
  assign prev_c   = str_mem[IDX_W'(start_reg - LEN_W'(1))];
  assign pat_c    = pat_mem[PA_W'(pi_reg)];
  assign chars_eq = (pat_c == CH_DOT) || (fold(str_c) == fold(pat_c));
  assign at_first = (pi_reg == p0) && !star_act_reg;

  logic found, fail, skip, take_star, retry, advance, exhausted;
  always_comb begin
    found = 1'b0; fail = 1'b0; skip = 1'b0; take_star = 1'b0;
    if (str_len_reg == '0)
      skip = 1'b1;
    else if (at_first && anc_s_reg && start_reg != '0 && prev_c != CH_SP)
      skip = 1'b1;
    else if (pi_reg == pe) begin
      if (!anc_e_reg || si_reg == str_len_reg || str_c == CH_SP) found = 1'b1;
      else fail = 1'b1;
    end else if (star_ok_reg && pi_reg == star_pos_reg && !star_act_reg)
      take_star = 1'b1;
    else if (!(si_reg < str_len_reg && chars_eq))
      fail = 1'b1;
  end
  // A failing suffix first lets the '*' swallow one more character.
  assign retry     = fail && star_act_reg && (bt_reg < str_len_reg);
  assign advance   = (fail && !retry) || skip;
  assign exhausted = advance && ((start_reg + LEN_W'(1)) >= str_len_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      str_len_reg <= '0; pat_len_reg <= '0; s_ovf_reg <= 1'b0; p_ovf_reg <= 1'b0;
      anc_s_reg <= 1'b0; anc_e_reg <= 1'b0; star_ok_reg <= 1'b0; star_pos_reg <= '0;
      start_reg <= '0; si_reg <= '0; pi_reg <= '0; bt_reg <= '0; star_act_reg <= 1'b0;
      busy_reg <= 1'b0; valid_reg <= 1'b0; match_reg <= 1'b0; idx_reg <= '0; ovf_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (state_reg == DONE) begin
            valid_reg <= 1'b0; busy_reg <= 1'b0; pat_len_reg <= '0; p_ovf_reg <= 1'b0;
          end
          if (bus.isstring) begin
            state_reg <= RECV_S; str_len_reg <= LEN_W'(1); s_ovf_reg <= 1'b0;
          end else if (bus.ispattern) begin
            state_reg <= RECV_P; pat_len_reg <= PI_W'(1); p_ovf_reg <= 1'b0;
          end else
            state_reg <= IDLE;
        end
        RECV_S: begin
          if (bus.isstring) begin
            if (str_len_reg < STR_CAP) str_len_reg <= str_len_reg + LEN_W'(1);
            else s_ovf_reg <= 1'b1;
          end else if (bus.ispattern) begin
            state_reg <= RECV_P; pat_len_reg <= PI_W'(1); p_ovf_reg <= 1'b0;
          end else
            state_reg <= IDLE;
        end
        RECV_P: begin
          if (pat_app) begin
            if (pat_len_reg < PAT_CAP) pat_len_reg <= pat_len_reg + PI_W'(1);
            else p_ovf_reg <= 1'b1;
          end else begin
            state_reg <= SEARCH; busy_reg <= 1'b1;
            start_reg <= '0; si_reg <= '0; pi_reg <= p0; star_act_reg <= 1'b0;
          end
        end
        SEARCH: begin
          if (found || exhausted) begin
            state_reg <= DONE; valid_reg <= 1'b1; match_reg <= found;
            idx_reg <= found ? IDX_W'(start_reg) : '0;
            ovf_reg <= s_ovf_reg | p_ovf_reg;
          end else if (retry) begin
            bt_reg <= bt_reg + LEN_W'(1); si_reg <= bt_reg + LEN_W'(1);
            pi_reg <= star_pos_reg + PI_W'(1);
          end else if (advance) begin
            start_reg <= start_reg + LEN_W'(1); si_reg <= start_reg + LEN_W'(1);
            pi_reg <= p0; star_act_reg <= 1'b0;
          end else if (take_star) begin
            bt_reg <= si_reg; pi_reg <= pi_reg + PI_W'(1); star_act_reg <= 1'b1;
          end else begin
            si_reg <= si_reg + LEN_W'(1); pi_reg <= pi_reg + PI_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
      // Anchor/star bookkeeping tracks each stored pattern character as it arrives.
      if (pat_wr) begin
        anc_e_reg <= (bus.chardata == CH_DOLL);
        if (pat_first) begin
          anc_s_reg    <= (bus.chardata == CH_CARET);
          star_ok_reg  <= (bus.chardata == CH_STAR);
          star_pos_reg <= '0;
        end else if (bus.chardata == CH_STAR && !star_ok_reg) begin
          star_ok_reg  <= 1'b1;
          star_pos_reg <= pat_len_reg;
        end
      end
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.valid       = valid_reg;
  assign bus.match       = match_reg;
  assign bus.match_index = idx_reg;
  assign bus.ovf         = ovf_reg;
endmodule
